bus_arbiter: RTL

//   Round-robin arbiter and sequencer for one shared 16-bit data bus.

---
 rtl/bus_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin arbiter and sequencer for one shared data bus. It picks one of
// four bus masters (fetch, load/store, DMA, debug), drives the select of the
// bus multiplexer tree and registers the owner's word onto the bus.
// A hold timeout stops a single owner from keeping the bus while others wait.
//
// Ports
//   clk        in   1                 rising-edge clock
//   rst        in   1                 synchronous reset, active-high
//   req        in   N_REQ             per-requester request (level)
//   data_in    in   N_REQ*DATA_WIDTH  requester words, word i at [DW*i +: DW]
//   grant      out  N_REQ             one-hot grant, 0 while the bus is free
//   bus_sel    out  2                 index of current/last owner (mux select)
//   bus_data   out  DATA_WIDTH        registered bus word
//   bus_valid  out  1                 bus_data holds a word from current owner
//
// Request/grant protocol: a requester raises req[i] and holds it high for as
// long as it wants the bus. grant[i] rises one cycle after req[i] is first
// seen by an idle arbiter that picks it. While grant[i] is high, every edge
// with req[i] high transfers data_in word i onto bus_data (bus_valid=1 from
// the following cycle). Dropping req[i] releases the bus at the next edge.
// A forced release (timeout under contention) also clears grant[i]; the
// requester then waits for its next round-robin turn. Every hand-over passes
// through one cycle with grant=0.
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_HOLD   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] data_in,
    output logic [N_REQ-1:0]            grant,
    output logic [1:0]                  bus_sel,
    output logic [DATA_WIDTH-1:0]       bus_data,
    output logic                        bus_valid
);

    localparam int SEL_W  = 2;
    localparam int HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Registered state
    state_e                  state_q,      state_d;
    logic [N_REQ-1:0]        grant_q,      grant_d;
    logic [SEL_W-1:0]        bus_sel_q,    bus_sel_d;
    logic [DATA_WIDTH-1:0]   bus_data_q,   bus_data_d;
    logic                    bus_valid_q,  bus_valid_d;
    logic [SEL_W-1:0]        last_owner_q, last_owner_d;
    logic [HOLD_W-1:0]       hold_cnt_q,   hold_cnt_d;

    // Unpacked view of the requester words
    logic [DATA_WIDTH-1:0]   words [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            words[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin pick: first set request searched upward from last_owner+1.
    // The 2-bit candidate index wraps 3->0 on its own since N_REQ is 4.
    logic             winner_found;
    logic [SEL_W-1:0] winner_idx;
    logic [SEL_W-1:0] cand_idx;

    always_comb begin
        winner_found = 1'b0;
        winner_idx   = '0;
        cand_idx     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_idx = last_owner_q + SEL_W'(k);
            if (!winner_found && req[cand_idx]) begin
                winner_found = 1'b1;
                winner_idx   = cand_idx;
            end
        end
    end

    // Owner status while BUSY
    logic [N_REQ-1:0] owner_onehot;
    logic             owner_req;
    logic             others_req;
    logic             hold_expired;

    always_comb begin
        owner_onehot = N_REQ'(1) << bus_sel_q;
        owner_req    = req[bus_sel_q];
        others_req   = |(req & ~owner_onehot);
        hold_expired = (hold_cnt_q == HOLD_MAX);
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        bus_sel_d    = bus_sel_q;
        bus_data_d   = bus_data_q;
        bus_valid_d  = bus_valid_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;

        case (state_q)
            ST_IDLE: begin
                grant_d     = '0;
                bus_valid_d = 1'b0;
                if (winner_found) begin
                    state_d    = ST_BUSY;
                    grant_d    = N_REQ'(1) << winner_idx;
                    bus_sel_d  = winner_idx;
                    hold_cnt_d = '0;
                end
            end

            ST_BUSY: begin
                // Voluntary release, or forced release once the hold budget
                // is spent and someone else is waiting. bus_data keeps the
                // last word so downstream sees a stable value while idle.
                if (!owner_req || (hold_expired && others_req)) begin
                    state_d      = ST_IDLE;
                    grant_d      = '0;
                    bus_valid_d  = 1'b0;
                    last_owner_d = bus_sel_q;
                end else begin
                    bus_data_d  = words[bus_sel_q];
                    bus_valid_d = 1'b1;
                    // Saturate so an uncontested owner keeps the bus and the
                    // release fires on the first edge that sees contention.
                    if (!hold_expired) begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            bus_sel_q    <= '0;
            bus_data_q   <= '0;
            bus_valid_q  <= 1'b0;
            // Requester 0 gets top priority out of reset.
            last_owner_q <= SEL_W'(N_REQ - 1);
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            bus_sel_q    <= bus_sel_d;
            bus_data_q   <= bus_data_d;
            bus_valid_q  <= bus_valid_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign grant     = grant_q;
    assign bus_sel   = bus_sel_q;
    assign bus_data  = bus_data_q;
    assign bus_valid = bus_valid_q;

endmodule
